// File: rtl/wb_pkg.sv
// Shared write-back definitions: register/data widths and the queue entry layout.
package wb_pkg;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority match across queue entries presented youngest-first (index 0 = youngest).
module wb_fwd_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = wb_pkg::AW,
  parameter int unsigned DW    = wb_pkg::DW
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] rd,
  input  logic [DEPTH-1:0][DW-1:0] data,
  input  logic [AW-1:0]            key,
  output logic                     hit,
  output logic [DW-1:0]            value
);

  // Scan oldest to youngest so the last (youngest) match overrides earlier ones.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[DEPTH-1-i] && (rd[DEPTH-1-i] == key)) begin
        hit   = 1'b1;
        value = data[DEPTH-1-i];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back staging queue: two producers in, one register-file write
// port out, with forwarding of pending results to the two read ports.
module writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = wb_pkg::AW,
  parameter int unsigned DW    = wb_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in_valid,
  output logic [1:0]           in_ready,
  input  logic [1:0][AW-1:0]   in_reg,
  input  logic [1:0][DW-1:0]   in_data,
  output logic                 RegWrite,
  output logic [0:0][AW-1:0]   write_reg,
  output logic [0:0][DW-1:0]   write_data,
  input  logic [1:0][AW-1:0]   fwd_reg,
  output logic [1:0]           fwd_hit,
  output logic [1:0][DW-1:0]   fwd_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] ent_rd   [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [AW-1:0] last_rd;
  logic [DW-1:0] last_data;

  logic          acc0;
  logic          acc1;
  logic          drain;
  logic [PW-1:0] tail1;

  logic [DEPTH-1:0]         age_valid;
  logic [DEPTH-1:0][AW-1:0] age_rd;
  logic [DEPTH-1:0][DW-1:0] age_data;

  // Readiness looks only at registered occupancy; the same-cycle drain is not credited.
  assign in_ready[0] = (count < CW'(DEPTH));
  assign in_ready[1] = (count < CW'(DEPTH - 1));

  assign acc0  = in_valid[0] & in_ready[0];
  assign acc1  = in_valid[1] & in_ready[1];
  assign drain = (count != '0);
  // Port 1 lands right after port 0 when both are taken, otherwise at tail.
  assign tail1 = tail + PW'(acc0);

  // Queue state: enqueue at tail, retire the head every cycle the queue is non-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      last_rd   <= '0;
      last_data <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (acc0) begin
        ent_rd[tail]   <= in_reg[0];
        ent_data[tail] <= in_data[0];
      end
      if (acc1) begin
        ent_rd[tail1]   <= in_reg[1];
        ent_data[tail1] <= in_data[1];
      end
      if (drain) begin
        head      <= head + 1'b1;
        last_rd   <= ent_rd[head];
        last_data <= ent_data[head];
      end
      tail  <= tail + PW'(acc0) + PW'(acc1);
      count <= count + CW'(acc0) + CW'(acc1) - CW'(drain);
    end
  end

  // Write port: head entry while non-empty; otherwise hold the last committed values.
  always_comb begin
    RegWrite      = drain;
    write_reg[0]  = drain ? ent_rd[head]   : last_rd;
    write_data[0] = drain ? ent_data[head] : last_data;
  end

  // Reorder live entries youngest-first (slot k = tail-1-k) for the priority search.
  always_comb begin
    age_valid = '0;
    age_rd    = '0;
    age_data  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx          = tail - PW'(k + 1);
      age_valid[k] = (CW'(k) < count);
      age_rd[k]    = ent_rd[idx];
      age_data[k]  = ent_data[idx];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_fwd
    wb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
    ) u_match (
      .valid (age_valid),
      .rd    (age_rd),
      .data  (age_data),
      .key   (fwd_reg[p]),
      .hit   (fwd_hit[p]),
      .value (fwd_data[p])
    );
  end

endmodule
